subkey_store: RTL and testbench
===============================

Name: subkey_store

Overview:
- Downstream of the Serpent key-schedule stage. Captures the 33 128-bit round subkeys as they are produced (address plus subkey plus write strobe), and tracks which entries are filled.
- Once the full set is present and the schedule signals completion, serves subkeys to the round datapath.
- Two read modes: random read by round index, or an auto-sequenced stream in forward (encrypt) or reverse (decrypt) order.
- Read latency is one cycle.

Parameters:
- NUM_SUBKEYS, 33, number of subkeys stored (rounds 0..32)
- ADDR_W, 6, subkey index width
- KEY_W, 128, subkey width

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rstn  input  1  synchronous active-low reset
- i_load_start  input  1  pulse: discard stored set, begin new load
- i_wr_en  input  1  subkey write strobe from key schedule
- i_wr_addr  input  ADDR_W  subkey index being written
- i_wr_subkey  input  KEY_W  subkey data
- i_key_done  input  1  key-schedule completion level (key valid)
- i_rd_req  input  1  random read request
- i_rd_addr  input  ADDR_W  random read index
- i_seq_start  input  1  pulse: start sequential stream
- i_seq_reverse  input  1  stream order, 0 = 0..32, 1 = 32..0 (sampled at i_seq_start)
- o_rd_subkey  output  KEY_W  read data
- o_rd_valid  output  1  o_rd_subkey valid this cycle
- o_rd_index  output  ADDR_W  index of o_rd_subkey
- o_seq_last  output  1  high with final stream beat
- o_ready  output  1  full set loaded, reads allowed
- o_error  output  1  sticky error flag

Behaviour:
- Reset (i_rstn low at a clock edge):
  - State = EMPTY; fill bitmap cleared; stream inactive.
  - All outputs 0 (o_rd_subkey, o_rd_index, o_rd_valid, o_seq_last, o_ready, o_error).
  - Storage contents need not be cleared.
  - Reset mid-load or mid-stream aborts immediately.
- States: EMPTY, LOADING, READY.
- EMPTY:
  - i_load_start -> LOADING, bitmap cleared.
  - i_wr_en here is also accepted: implicit start, enter LOADING and write the entry.
- LOADING:
  - i_wr_en with i_wr_addr < NUM_SUBKEYS: write the storage entry and set its bitmap bit.
  - A rewrite of the same index overwrites (last write wins).
  - i_wr_en with i_wr_addr >= NUM_SUBKEYS: write dropped, o_error set.
  - Transition to READY when all 33 bitmap bits are set and i_key_done is high, evaluated on registered bitmap.
  - o_ready rises the cycle after the last required condition is met.
  - i_key_done high with bits missing: stay LOADING, o_error set.
- READY:
  - o_ready = 1; reads served.
  - i_wr_en in READY: ignored, o_error set.
  - i_load_start -> LOADING: o_ready drops next cycle, bitmap cleared, any active stream aborted (no further o_rd_valid).
  - i_load_start in any state clears o_error.
  - i_load_start and i_wr_en in the same cycle: clear first, then the write is applied as first entry of the new set.
- Random read:
  - i_rd_req in READY with i_rd_addr < 33 -> next cycle o_rd_valid = 1, o_rd_subkey = entry, o_rd_index = i_rd_addr.
  - Out-of-range address or not READY -> no valid, o_error set.
- Sequential stream:
  - i_seq_start in READY latches direction.
  - Starting the cycle after, one beat per cycle for 33 consecutive cycles.
  - Index order is 0..32 forward or 32..0 reverse.
  - o_seq_last accompanies index 32 (forward) or 0 (reverse).
  - No stall input; beats are back-to-back.
- Read priority:
  - An active stream owns the read port; i_rd_req during a stream is ignored and sets o_error.
  - i_seq_start during an active stream is ignored and sets o_error.
  - i_seq_start and i_rd_req in the same cycle: stream wins, o_error set.
- Counter wrap: stream counter stops after last beat; no wrap to a 34th beat.
- o_rd_valid is a single-cycle pulse per beat/read; o_rd_subkey holds its last value when not valid.

Test Plan:
- Reset, then load indices 0..32 with subkey = {4{32'h0000_0100 + idx}} and assert i_key_done -> o_ready = 1 one cycle later; random read of addr 5 -> next cycle o_rd_valid = 1, o_rd_subkey = 128'h00000105_00000105_00000105_00000105, o_rd_index = 5.
- Load only 0..31, assert i_key_done -> o_ready stays 0, o_error = 1; write index 32 -> o_ready = 1 next cycle.
- In READY, i_seq_start with i_seq_reverse = 0 -> 33 consecutive beats with indices 0..32 and o_seq_last only on 32; repeat with reverse = 1 -> indices 32..0, o_seq_last on 0.
- Write with i_wr_addr = 40 during load -> no storage change, o_error = 1; then i_load_start -> o_error = 0, o_ready = 0.
- Start a stream, assert i_load_start at beat 10 -> o_rd_valid low from the next cycle, state LOADING, o_ready = 0.
- Read request while LOADING, and i_rd_req during an active stream -> no extra o_rd_valid, o_error = 1; drive i_rstn low mid-stream -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/subkey_store_if.sv
// Bus between the Serpent key schedule, the subkey store and the round datapath.
// The master drives the i_* requests; the slave (the store) answers on o_*.
interface subkey_store_if #(
    parameter int ADDR_W = 6,
    parameter int KEY_W  = 128
);
    logic              i_load_start;
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [KEY_W-1:0]  i_wr_subkey;
    logic              i_key_done;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_seq_start;
    logic              i_seq_reverse;
    logic [KEY_W-1:0]  o_rd_subkey;
    logic              o_rd_valid;
    logic [ADDR_W-1:0] o_rd_index;
    logic              o_seq_last;
    logic              o_ready;
    logic              o_error;

    modport master (
        output i_load_start, i_wr_en, i_wr_addr, i_wr_subkey, i_key_done,
               i_rd_req, i_rd_addr, i_seq_start, i_seq_reverse,
        input  o_rd_subkey, o_rd_valid, o_rd_index, o_seq_last, o_ready, o_error
    );

    modport slave (
        input  i_load_start, i_wr_en, i_wr_addr, i_wr_subkey, i_key_done,
               i_rd_req, i_rd_addr, i_seq_start, i_seq_reverse,
        output o_rd_subkey, o_rd_valid, o_rd_index, o_seq_last, o_ready, o_error
    );
endinterface

// File: rtl/subkey_store.sv
// Serpent round-subkey store: captures the 33 subkeys from the key schedule and
// serves them by random index or as a forward/reverse back-to-back stream.
module subkey_store #(
    parameter int NUM_SUBKEYS = 33,
    parameter int ADDR_W      = 6,
    parameter int KEY_W       = 128
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    subkey_store_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SUBKEYS - 1);

    typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_READY} state_t;

    state_t                 state_q, state_nxt;
    logic [NUM_SUBKEYS-1:0] fill_q, fill_nxt;
    logic                   err_q, err_nxt;
    logic                   seq_act_q, seq_act_nxt;
    logic                   seq_rev_q, seq_rev_nxt;
    logic [ADDR_W-1:0]      seq_idx_q, seq_idx_nxt;

    logic                   wr_acc;
    logic                   iss_vld;
    logic                   iss_last;
    logic [ADDR_W-1:0]      iss_idx;

    logic [KEY_W-1:0]       mem [NUM_SUBKEYS];

    logic [KEY_W-1:0]       rd_subkey_p1;
    logic [ADDR_W-1:0]      rd_index_p1;
    logic                   vld_p1;
    logic                   seq_last_p1;

    logic                   wr_ok;
    logic                   rd_ok;
    logic [NUM_SUBKEYS-1:0] wr_bit;

    assign wr_ok  = (bus.i_wr_addr <= LAST_IDX);
    assign rd_ok  = (bus.i_rd_addr <= LAST_IDX);
    assign wr_bit = NUM_SUBKEYS'(1) << bus.i_wr_addr;

    always_comb begin
        state_nxt   = state_q;
        fill_nxt    = fill_q;
        err_nxt     = err_q;
        seq_act_nxt = seq_act_q;
        seq_rev_nxt = seq_rev_q;
        seq_idx_nxt = seq_idx_q;
        wr_acc      = 1'b0;
        iss_vld     = 1'b0;
        iss_last    = 1'b0;
        iss_idx     = '0;

        // A new load wipes the set first so a same-cycle write lands in the new set.
        if (bus.i_load_start) begin
            state_nxt   = S_LOADING;
            fill_nxt    = '0;
            err_nxt     = 1'b0;
            seq_act_nxt = 1'b0;
        end

        if (bus.i_wr_en) begin
            if (state_q == S_READY && !bus.i_load_start) begin
                err_nxt = 1'b1;
            end else begin
                if (state_q == S_EMPTY) state_nxt = S_LOADING;
                if (wr_ok) begin
                    wr_acc   = 1'b1;
                    fill_nxt = fill_nxt | wr_bit;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end

        // Completion looks at the registered bitmap, so the last write must land first.
        if (state_q == S_LOADING && !bus.i_load_start && bus.i_key_done) begin
            if (&fill_q) state_nxt = S_READY;
            else         err_nxt   = 1'b1;
        end

        if (state_q == S_READY && !bus.i_load_start) begin
            if (seq_act_q) begin
                iss_vld  = 1'b1;
                iss_idx  = seq_idx_q;
                iss_last = seq_rev_q ? (seq_idx_q == '0) : (seq_idx_q == LAST_IDX);
                if (iss_last) seq_act_nxt = 1'b0;
                else          seq_idx_nxt = seq_rev_q ? seq_idx_q - ADDR_W'(1)
                                                      : seq_idx_q + ADDR_W'(1);
                if (bus.i_rd_req || bus.i_seq_start) err_nxt = 1'b1;
            end else if (bus.i_seq_start) begin
                iss_vld     = 1'b1;
                iss_idx     = bus.i_seq_reverse ? LAST_IDX : '0;
                seq_act_nxt = 1'b1;
                seq_rev_nxt = bus.i_seq_reverse;
                seq_idx_nxt = bus.i_seq_reverse ? LAST_IDX - ADDR_W'(1) : ADDR_W'(1);
                if (bus.i_rd_req) err_nxt = 1'b1;
            end else if (bus.i_rd_req) begin
                if (rd_ok) begin
                    iss_vld = 1'b1;
                    iss_idx = bus.i_rd_addr;
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end else if (bus.i_rd_req || bus.i_seq_start) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= S_EMPTY;
            fill_q       <= '0;
            err_q        <= 1'b0;
            seq_act_q    <= 1'b0;
            seq_rev_q    <= 1'b0;
            seq_idx_q    <= '0;
            vld_p1       <= 1'b0;
            seq_last_p1  <= 1'b0;
            rd_subkey_p1 <= '0;
            rd_index_p1  <= '0;
        end else begin
            state_q     <= state_nxt;
            fill_q      <= fill_nxt;
            err_q       <= err_nxt;
            seq_act_q   <= seq_act_nxt;
            seq_rev_q   <= seq_rev_nxt;
            seq_idx_q   <= seq_idx_nxt;
            // read stage: output register holds its last beat when idle
            vld_p1      <= iss_vld;
            seq_last_p1 <= iss_vld & iss_last;
            if (iss_vld) begin
                rd_subkey_p1 <= mem[iss_idx];
                rd_index_p1  <= iss_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[bus.i_wr_addr] <= bus.i_wr_subkey;
    end

    assign bus.o_rd_subkey = rd_subkey_p1;
    assign bus.o_rd_valid  = vld_p1;
    assign bus.o_rd_index  = rd_index_p1;
    assign bus.o_seq_last  = seq_last_p1;
    assign bus.o_ready     = (state_q == S_READY);
    assign bus.o_error     = err_q;
endmodule

// File: tb/tb_subkey_store.sv
// Bench for subkey_store: directed sequences, a read-vector table and random
// traffic, all compared against a queue-based model of the store.
module tb_subkey_store;
    localparam int N  = 33;
    localparam int AW = 6;
    localparam int KW = 128;
    localparam int M_EMPTY = 0, M_LOAD = 1, M_READY = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    subkey_store_if #(.ADDR_W(AW), .KEY_W(KW)) bus ();

    subkey_store #(.NUM_SUBKEYS(N), .ADDR_W(AW), .KEY_W(KW)) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [KW-1:0] m_store [N];
    bit            m_fill  [N];
    int            m_mode;
    bit            m_err;
    int            m_beats [$];
    logic          e_vld, e_last;
    logic [AW-1:0] e_idx;
    logic [KW-1:0] e_key;

    typedef struct {
        logic [AW-1:0] addr;
        logic          exp_vld;
        logic [KW-1:0] exp_key;
        logic          exp_err;
    } rd_vec_t;
    rd_vec_t tbl [$];

    function automatic logic [KW-1:0] pat(input int idx);
        logic [31:0] w;
        w = 32'h0000_0100 + 32'(idx);
        return {w, w, w, w};
    endfunction

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_EMPTY;
        m_err  = 1'b0;
        foreach (m_fill[i]) m_fill[i] = 1'b0;
        m_beats.delete();
        e_vld  = 1'b0;
        e_last = 1'b0;
        e_idx  = '0;
        e_key  = '0;
    endtask

    task automatic emit(input int idx, input bit last);
        e_vld  = 1'b1;
        e_idx  = AW'(idx);
        e_key  = m_store[idx];
        e_last = last;
    endtask

    // Next-cycle expectations from the current inputs and the model's set/stream state.
    task automatic model_step();
        int cnt;
        int old_mode;
        bit ld;
        cnt      = 0;
        old_mode = m_mode;
        ld       = bus.i_load_start;
        foreach (m_fill[i]) cnt += int'(m_fill[i]);
        e_vld  = 1'b0;
        e_last = 1'b0;
        if (ld) begin
            m_mode = M_LOAD;
            m_err  = 1'b0;
            foreach (m_fill[i]) m_fill[i] = 1'b0;
            m_beats.delete();
        end
        if (old_mode == M_READY && !ld) begin
            if (m_beats.size() > 0) begin
                int b;
                b = m_beats.pop_front();
                emit(b, m_beats.size() == 0);
                if (bus.i_rd_req || bus.i_seq_start) m_err = 1'b1;
            end else if (bus.i_seq_start) begin
                for (int k = 0; k < N; k++) m_beats.push_back(bus.i_seq_reverse ? N - 1 - k : k);
                emit(m_beats.pop_front(), 1'b0);
                if (bus.i_rd_req) m_err = 1'b1;
            end else if (bus.i_rd_req) begin
                if (int'(bus.i_rd_addr) < N) emit(int'(bus.i_rd_addr), 1'b0);
                else m_err = 1'b1;
            end
        end else if (bus.i_rd_req || bus.i_seq_start) begin
            m_err = 1'b1;
        end
        if (bus.i_wr_en) begin
            if (old_mode == M_READY && !ld) begin
                m_err = 1'b1;
            end else begin
                if (old_mode == M_EMPTY) m_mode = M_LOAD;
                if (int'(bus.i_wr_addr) < N) begin
                    m_store[int'(bus.i_wr_addr)] = bus.i_wr_subkey;
                    m_fill[int'(bus.i_wr_addr)]  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (old_mode == M_LOAD && !ld && bus.i_key_done) begin
            if (cnt == N) m_mode = M_READY;
            else          m_err  = 1'b1;
        end
    endtask

    task automatic tick();
        if (!rstn) model_reset();
        else       model_step();
        @(posedge clk);
        #1;
        chk("m_rd_valid",  KW'(bus.o_rd_valid), KW'(e_vld));
        chk("m_rd_index",  KW'(bus.o_rd_index), KW'(e_idx));
        chk("m_rd_subkey", bus.o_rd_subkey,     e_key);
        chk("m_seq_last",  KW'(bus.o_seq_last), KW'(e_last));
        chk("m_ready",     KW'(bus.o_ready),    KW'(m_mode == M_READY));
        chk("m_error",     KW'(bus.o_error),    KW'(m_err));
    endtask

    task automatic idle();
        bus.i_load_start  = 1'b0;
        bus.i_wr_en       = 1'b0;
        bus.i_wr_addr     = '0;
        bus.i_wr_subkey   = '0;
        bus.i_key_done    = 1'b0;
        bus.i_rd_req      = 1'b0;
        bus.i_rd_addr     = '0;
        bus.i_seq_start   = 1'b0;
        bus.i_seq_reverse = 1'b0;
    endtask

    task automatic load_range(input int last, input bit use_pat);
        for (int i = 0; i <= last; i++) begin
            bus.i_wr_en     = 1'b1;
            bus.i_wr_addr   = AW'(i);
            bus.i_wr_subkey = use_pat ? pat(i) : {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        bus.i_wr_en = 1'b0;
    endtask

    task automatic finish_load();
        bus.i_key_done = 1'b1;
        tick();
        bus.i_key_done = 1'b0;
    endtask

    task automatic run_stream(input bit rev, input bit use_pat);
        bus.i_seq_start   = 1'b1;
        bus.i_seq_reverse = rev;
        tick();
        bus.i_seq_start   = 1'b0;
        for (int b = 0; b < N; b++) begin
            int idx;
            idx = rev ? N - 1 - b : b;
            chk("stream_valid", KW'(bus.o_rd_valid), KW'(1));
            chk("stream_index", KW'(bus.o_rd_index), KW'(idx));
            chk("stream_last",  KW'(bus.o_seq_last), KW'(idx == (rev ? 0 : N - 1)));
            if (use_pat) chk("stream_key", bus.o_rd_subkey, pat(idx));
            tick();
        end
        chk("stream_no_wrap", KW'(bus.o_rd_valid), KW'(0));
    endtask

    initial begin
        idle();
        model_reset();

        // Reset: every output low.
        rstn = 1'b0;
        tick();
        tick();
        chk("reset_valid", KW'(bus.o_rd_valid), KW'(0));
        chk("reset_ready", KW'(bus.o_ready),    KW'(0));
        chk("reset_error", KW'(bus.o_error),    KW'(0));
        chk("reset_key",   bus.o_rd_subkey,     KW'(0));
        rstn = 1'b1;
        tick();

        // Full load starting from EMPTY (implicit start), then key_done.
        load_range(N - 1, 1'b1);
        chk("load_not_ready_yet", KW'(bus.o_ready), KW'(0));
        finish_load();
        chk("load_ready", KW'(bus.o_ready), KW'(1));
        chk("load_no_error", KW'(bus.o_error), KW'(0));

        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = AW'(5);
        tick();
        bus.i_rd_req  = 1'b0;
        chk("rd5_valid", KW'(bus.o_rd_valid), KW'(1));
        chk("rd5_key",   bus.o_rd_subkey, 128'h00000105_00000105_00000105_00000105);
        chk("rd5_index", KW'(bus.o_rd_index), KW'(5));
        tick();
        chk("rd5_pulse", KW'(bus.o_rd_valid), KW'(0));

        // Random-read vectors; error is sticky once an out-of-range read appears.
        tbl.push_back('{AW'(0),  1'b1, pat(0),  1'b0});
        tbl.push_back('{AW'(32), 1'b1, pat(32), 1'b0});
        tbl.push_back('{AW'(17), 1'b1, pat(17), 1'b0});
        tbl.push_back('{AW'(1),  1'b1, pat(1),  1'b0});
        tbl.push_back('{AW'(33), 1'b0, '0,      1'b1});
        tbl.push_back('{AW'(63), 1'b0, '0,      1'b1});
        tbl.push_back('{AW'(9),  1'b1, pat(9),  1'b1});
        foreach (tbl[i]) begin
            bus.i_rd_req  = 1'b1;
            bus.i_rd_addr = tbl[i].addr;
            tick();
            bus.i_rd_req  = 1'b0;
            chk("tbl_valid", KW'(bus.o_rd_valid), KW'(tbl[i].exp_vld));
            chk("tbl_error", KW'(bus.o_error),    KW'(tbl[i].exp_err));
            if (tbl[i].exp_vld) begin
                chk("tbl_key",   bus.o_rd_subkey,     tbl[i].exp_key);
                chk("tbl_index", KW'(bus.o_rd_index), KW'(tbl[i].addr));
            end
        end

        run_stream(1'b0, 1'b1);
        run_stream(1'b1, 1'b1);

        // Partial set: key_done with index 32 missing.
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        chk("reload_err_clear", KW'(bus.o_error), KW'(0));
        chk("reload_not_ready", KW'(bus.o_ready), KW'(0));
        load_range(N - 2, 1'b1);
        bus.i_key_done = 1'b1;
        tick();
        chk("partial_not_ready", KW'(bus.o_ready), KW'(0));
        chk("partial_error",     KW'(bus.o_error), KW'(1));
        bus.i_wr_en     = 1'b1;
        bus.i_wr_addr   = AW'(32);
        bus.i_wr_subkey = pat(32);
        tick();
        bus.i_wr_en = 1'b0;
        tick();
        bus.i_key_done = 1'b0;
        chk("partial_then_ready", KW'(bus.o_ready), KW'(1));

        // Out-of-range write during load.
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        bus.i_wr_en     = 1'b1;
        bus.i_wr_addr   = AW'(40);
        bus.i_wr_subkey = {4{32'hDEAD_BEEF}};
        tick();
        bus.i_wr_en = 1'b0;
        chk("badwr_error", KW'(bus.o_error), KW'(1));
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        chk("badwr_clear", KW'(bus.o_error), KW'(0));
        chk("badwr_ready", KW'(bus.o_ready), KW'(0));
        load_range(N - 1, 1'b0);
        finish_load();

        // Abort a stream at beat 10 with a new load.
        bus.i_seq_start   = 1'b1;
        bus.i_seq_reverse = 1'b0;
        tick();
        bus.i_seq_start = 1'b0;
        for (int b = 0; b < 10; b++) tick();
        chk("abort_at_beat10", KW'(bus.o_rd_index), KW'(10));
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        chk("abort_valid", KW'(bus.o_rd_valid), KW'(0));
        chk("abort_ready", KW'(bus.o_ready),    KW'(0));
        tick();
        chk("abort_valid2", KW'(bus.o_rd_valid), KW'(0));
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = AW'(3);
        tick();
        bus.i_rd_req  = 1'b0;
        chk("loading_rd_valid", KW'(bus.o_rd_valid), KW'(0));
        chk("loading_rd_error", KW'(bus.o_error),    KW'(1));

        // Read request during a stream, then reset mid-stream.
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
        load_range(N - 1, 1'b0);
        finish_load();
        chk("stream2_err_clear", KW'(bus.o_error), KW'(0));
        bus.i_seq_start   = 1'b1;
        bus.i_seq_reverse = 1'b1;
        tick();
        bus.i_seq_start = 1'b0;
        tick();
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = AW'(7);
        tick();
        bus.i_rd_req  = 1'b0;
        chk("stream_rd_index", KW'(bus.o_rd_index), KW'(30));
        chk("stream_rd_error", KW'(bus.o_error),    KW'(1));
        rstn = 1'b0;
        tick();
        chk("midrst_valid", KW'(bus.o_rd_valid), KW'(0));
        chk("midrst_index", KW'(bus.o_rd_index), KW'(0));
        chk("midrst_key",   bus.o_rd_subkey,     KW'(0));
        chk("midrst_last",  KW'(bus.o_seq_last), KW'(0));
        chk("midrst_ready", KW'(bus.o_ready),    KW'(0));
        chk("midrst_error", KW'(bus.o_error),    KW'(0));
        rstn = 1'b1;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rstn              = ($urandom_range(0, 199) != 0);
            bus.i_load_start  = ($urandom_range(0, 99) < 2);
            bus.i_wr_en       = ($urandom_range(0, 99) < 50);
            bus.i_wr_addr     = AW'($urandom_range(0, 35));
            bus.i_wr_subkey   = {$urandom, $urandom, $urandom, $urandom};
            bus.i_key_done    = ($urandom_range(0, 99) < 30);
            bus.i_rd_req      = ($urandom_range(0, 99) < 25);
            bus.i_rd_addr     = AW'($urandom_range(0, 35));
            bus.i_seq_start   = ($urandom_range(0, 99) < 4);
            bus.i_seq_reverse = 1'($urandom_range(0, 1));
            tick();
        end
        rstn = 1'b1;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
